seq_add_n: RTL and testbench

SEQ_ADD_N -- requirements
Module: seq_add_n

---
 rtl/seq_add_n.sv | 85 ++++++++
 tb/tb_seq_add_n.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seq_add_n.sv
// seq_add_n: multi-cycle adder, one DIGIT slice per cycle LSB-first; `SEQ_ADD_OVF_EN adds signed overflow output ovf
module seq_add_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] ra, rb, acc, s_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   ss;
  int               idx;
  // current slice sum and the accumulator with that slice merged in
  always_comb begin
    idx   = int'(cnt) * DIGIT;
    ss    = {1'b0, ra[idx +: DIGIT]} + {1'b0, rb[idx +: DIGIT]} + (DIGIT+1)'(carry);
    s_nxt = acc;
    s_nxt[idx +: DIGIT] = ss[DIGIT-1:0];
  end
  // control FSM; partial sums live in acc so s only changes on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SEQ_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= start ? RUN : IDLE;
          busy  <= start;
          if (start) begin
            ra    <= a;
            rb    <= b;
            carry <= ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= ss[DIGIT];
          acc   <= s_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N-1)) begin
            s     <= s_nxt;
            co    <= ss[DIGIT];
`ifdef SEQ_ADD_OVF_EN
            ovf   <= ra[WIDTH-1] ^ rb[WIDTH-1] ^ s_nxt[WIDTH-1] ^ ss[DIGIT];
`endif
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_add_n.sv
// tb_seq_add_n: scoreboard bench for seq_add_n (16/4 and 8/8 instances); define SEQ_ADD_OVF_EN to also check ovf
module tb_seq_add_n;
  typedef struct {logic [15:0] s; logic co; logic ovf; int cyc;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci = 1'b0, start2 = 1'b0, ci2 = 1'b0;
  logic [15:0] a = '0, b = '0, s;
  logic [7:0] a2 = '0, b2 = '0, s2;
  logic busy, done, co, busy2, done2, co2;
`ifdef SEQ_ADD_OVF_EN
  logic ovf, ovf2;
`endif
  int cyc = 0, cmp = 0, err = 0;
  exp_t q[$], q2[$];

  seq_add_n #(.WIDTH(16), .DIGIT(4)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co)
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  seq_add_n #(.WIDTH(8), .DIGIT(8)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .ci(ci2),
    .busy(busy2), .done(done2), .s(s2), .co(co2)
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    cmp++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", n, got, exp, cyc);
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [15:0] ia, ib, input logic ici, input logic [15:0] es, input logic eco, eovf);
    a = ia; b = ib; ci = ici; start = 1'b1;
    q.push_back('{es, eco, eovf, cyc + 5});
  endtask

  // monitor for the 16-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("s", 32'(s), 32'(e.s));
        chk("co", 32'(co), 32'(e.co));
`ifdef SEQ_ADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // monitor for the 8-bit single-slice instance
  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        e = q2.pop_front();
        chk("s2", 32'(s2), 32'(e.s));
        chk("co2", 32'(co2), 32'(e.co));
`ifdef SEQ_ADD_OVF_EN
        chk("ovf2", 32'(ovf2), 32'(e.ovf));
`endif
        chk("done2_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_co", 32'(co), 0);
    rst_n = 1'b1;
    tick(1);
    go(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", 32'(busy), 1);
      tick(1);
    end
    chk("busy_after", 32'(busy), 0);
    chk("done_pulse", 32'(done), 1);
    tick(3);
    go(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    tick(1);
    start = 1'b0;
    tick(1);
    a = 16'hAAAA; b = 16'h5555; ci = 1'b1; start = 1'b1;
    q.push_back('{16'h0000, 1'b1, 1'b0, cyc + 8});
    tick(4);
    start = 1'b0;
    tick(6);
    go(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    tick(1);
    start = 1'b0;
    tick(7);
    a = 16'hFFFF; b = 16'h0001; ci = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_s", 32'(s), 0);
    chk("abort_co", 32'(co), 0);
    rst_n = 1'b1;
    go(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    tick(1);
    start = 1'b0;
    tick(8);
    go(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick(1);
    start = 1'b0;
    tick(6);
    go(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(6);
    a2 = 8'h80; b2 = 8'h80; ci2 = 1'b1; start2 = 1'b1;
    q2.push_back('{16'h0001, 1'b1, 1'b1, cyc + 2});
    tick(1);
    start2 = 1'b0;
    tick(3);
    for (int i = 0; i < 50 && (q.size() != 0 || q2.size() != 0); i++) tick(1);
    foreach (q[i]) chk("missing_done", 0, 1);
    foreach (q2[i]) chk("missing_done2", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
